// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//    Fetches 16-bit big-endian instructions from a byte-wide, combinationally
//    read instruction memory. Each instruction takes two memory reads: the
//    high byte at FetchPC, then the low byte at FetchPC+1. Completed
//    instructions are placed in a small FIFO, and the registered head of that
//    FIFO is presented to the datapath with a valid/ready handshake. A
//    redirect strobe flushes all in-flight work and restarts fetch at a new
//    address.
//
// Configuration:
//    FETCH_PREFETCH_EN  defined   -> queue depth 2 (one instruction per 2 cycles)
//    FETCH_PREFETCH_EN  undefined -> queue depth 1 (one instruction per 3 cycles)
//
// Parameters:
//    RESET_PC    fetch address loaded on reset
//
// Ports:
//    Clock       single clock, all state updates on the rising edge
//    ResetN      asynchronous, active-low reset
//    MemAddr     byte address to instruction memory
//    MemData     byte returned for MemAddr in the same cycle
//    InstrOut    head instruction, {byte@PC, byte@PC+1}
//    InstrPC     byte address of InstrOut's high byte
//    InstrValid  head holds a valid instruction
//    InstrReady  datapath consumes the head this cycle
//    Redirect    branch/jump redirect strobe (highest priority)
//    RedirectPC  new fetch address, any byte alignment
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'd9
) (
   input  logic        Clock,
   input  logic        ResetN,
   output logic [15:0] MemAddr,
   input  logic [7:0]  MemData,
   output logic [15:0] InstrOut,
   output logic [15:0] InstrPC,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic        Redirect,
   input  logic [15:0] RedirectPC
);

`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

   typedef enum logic {
      FETCH_HI = 1'b0,
      FETCH_LO = 1'b1
   } fetch_state_t;

   fetch_state_t state_q, state_d;
   logic [15:0]  fetch_pc_q, fetch_pc_d;
   logic [7:0]   hi_q, hi_d;
   logic [1:0]   count_q, count_d;
   logic         valid_q, valid_d;
   logic [15:0]  q_instr_q [DEPTH];
   logic [15:0]  q_instr_d [DEPTH];
   logic [15:0]  q_pc_q    [DEPTH];
   logic [15:0]  q_pc_d    [DEPTH];

   logic [15:0]  mem_addr;
   logic         push;
   logic         pop;
   int           head_cnt;
   int           wr_idx;

   // Fetch sequencer. The stall decision looks only at the registered
   // queue count, so a pop in the same cycle does not free a slot early.
   // A FETCH_HI read is only started when a slot is free, which guarantees
   // the push at the end of FETCH_LO always has room. Redirect overrides
   // everything and drops the half-assembled high byte.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      hi_d       = hi_q;
      mem_addr   = fetch_pc_q;
      push       = 1'b0;

      case (state_q)
         FETCH_HI: begin
            if (count_q < DEPTH_CNT) begin
               hi_d    = MemData;
               state_d = FETCH_LO;
            end
         end
         FETCH_LO: begin
            mem_addr   = fetch_pc_q + 16'd1;
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 16'd2;
            state_d    = FETCH_HI;
         end
      endcase

      if (Redirect) begin
         state_d    = FETCH_HI;
         fetch_pc_d = RedirectPC;
         hi_d       = 8'h00;
         push       = 1'b0;
      end
   end

   assign MemAddr = mem_addr;

   // Instruction queue, kept as a shift register so entry 0 is always the
   // head. When the last entry is popped nothing is shifted in, so the head
   // slot keeps its old contents and the outputs hold their last values
   // while InstrValid drops. On a simultaneous push and pop the new entry
   // lands one slot lower, in the position vacated by the shift.
   always_comb begin
      q_instr_d = q_instr_q;
      q_pc_d    = q_pc_q;
      count_d   = count_q;
      valid_d   = valid_q;
      pop       = valid_q & InstrReady;
      head_cnt  = int'(count_q);
      wr_idx    = pop ? head_cnt - 1 : head_cnt;

      if (Redirect) begin
         count_d = 2'd0;
         valid_d = 1'b0;
      end else begin
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               if (i + 1 < head_cnt) begin
                  q_instr_d[i] = q_instr_q[i + 1];
                  q_pc_d[i]    = q_pc_q[i + 1];
               end
            end
         end
         if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (i == wr_idx) begin
                  q_instr_d[i] = {hi_q, MemData};
                  q_pc_d[i]    = fetch_pc_q;
               end
            end
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
         valid_d = (count_d != 2'd0);
      end
   end

   // State registers. Reset is asynchronous so MemAddr and the outputs
   // take their reset values without waiting for a clock edge.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q    <= FETCH_HI;
         fetch_pc_q <= RESET_PC;
         hi_q       <= 8'h00;
         count_q    <= 2'd0;
         valid_q    <= 1'b0;
         q_instr_q  <= '{default: 16'h0000};
         q_pc_q     <= '{default: 16'h0000};
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         hi_q       <= hi_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         q_instr_q  <= q_instr_d;
         q_pc_q     <= q_pc_d;
      end
   end

   assign InstrOut   = q_instr_q[0];
   assign InstrPC    = q_pc_q[0];
   assign InstrValid = valid_q;

endmodule
